// File: rtl/pwm_multi.sv
// Multi-channel PWM with prescaled counter, optional bit-reversed compare and
// double-buffered thresholds that commit only at the counter wrap.
module pwm_multi #(
    parameter int NCH     = 2,
    parameter int WIDTH   = 6,
    parameter int PRE_W   = 4,
    parameter int REVERSE = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WE,
    input  logic [3:0]       WADDR,
    input  logic [WIDTH-1:0] WDATA,
    output logic [NCH-1:0]   PWM,
    output logic [NCH-1:0]   PENDING,
    output logic             TICK
);

    localparam logic [3:0]       ADDR_DIV  = 4'(NCH);
    localparam logic [3:0]       ADDR_CTRL = 4'(NCH + 1);
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cmp;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] div;
    logic             en;
    logic [WIDTH-1:0] shadow [NCH];
    logic [WIDTH-1:0] active [NCH];

    logic step;
    logic boundary;
    logic wr_ch;
    logic wr_div;
    logic wr_ctrl;
    logic force_load;

    always_comb begin
        cmp = cnt;
        if (REVERSE != 0) begin
            for (int b = 0; b < WIDTH; b++) begin
                cmp[b] = cnt[WIDTH-1-b];
            end
        end
    end

    assign step       = (pre == div);
    assign boundary   = step && (cnt == CNT_MAX);
    assign wr_ch      = WE && (WADDR < ADDR_DIV);
    assign wr_div     = WE && (WADDR == ADDR_DIV);
    assign wr_ctrl    = WE && (WADDR == ADDR_CTRL);
    assign force_load = wr_ctrl && WDATA[1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt     <= '0;
            pre     <= '0;
            div     <= '0;
            en      <= 1'b0;
            TICK    <= 1'b0;
            PWM     <= '0;
            PENDING <= '0;
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            // A force load restarts the period and overrides any step this cycle.
            if (force_load) begin
                cnt <= '0;
                pre <= '0;
            end else if (step) begin
                pre <= '0;
                cnt <= cnt + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end

            TICK <= boundary && !force_load;

            if (wr_div) begin
                div <= WDATA[PRE_W-1:0];
            end
            if (wr_ctrl) begin
                en <= WDATA[0];
            end

            for (int i = 0; i < NCH; i++) begin
                if (force_load || (boundary && PENDING[i])) begin
                    active[i]  <= shadow[i];
                    PENDING[i] <= 1'b0;
                end
                // A write on the commit cycle lands after the old shadow was copied.
                if (wr_ch && (WADDR == 4'(i))) begin
                    shadow[i]  <= WDATA;
                    PENDING[i] <= 1'b1;
                end
                PWM[i] <= en && (cmp < active[i]);
            end
        end
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel successor to the single 6-bit bit-reversed PWM audio output on the Gigatron extension board.
- Generalised to NCH channels of WIDTH bits each, with a programmable prescaler and an optional bit-reversed counter.
- Thresholds are double-buffered and committed only at a period boundary, so audio updates are glitch-free.
- Configured from the extended ctrl-code decoder through a simple one-cycle register-write port.

Parameters:
NCH, 2, number of PWM output channels (1..8)
WIDTH, 6, counter/threshold width in bits (4..10)
PRE_W, 4, prescaler divider width in bits; must be <= WIDTH
REVERSE, 1, 1 = compare against bit-reversed counter; 0 = plain counter

Ports:
CLK  in  1  system clock, all logic on posedge
RST  in  1  synchronous reset, active-high
WE  in  1  write strobe, one cycle per write
WADDR  in  4  register address: 0..NCH-1 = channel threshold shadow; NCH = divider; NCH+1 = control
WDATA  in  WIDTH  write data
PWM  out  NCH  registered PWM outputs
PENDING  out  NCH  per-channel shadow-not-yet-committed flags
TICK  out  1  registered one-cycle pulse at each counter period wrap

Behaviour:
- Interface: one clock, CLK. Reset is RST, synchronous and active-high; it is sampled only on posedge CLK.
- Reset values:
  - PWM=0, PENDING=0, TICK=0.
  - Counter cnt=0, prescaler pre=0, divider div=0, enable en=0.
  - All shadow and active thresholds = 0.
- Prescaler:
  - When pre==div, a step occurs: pre<=0 and cnt<=cnt+1, wrapping from 2^WIDTH-1 to 0.
  - Otherwise pre<=pre+1.
  - div=0 therefore steps every cycle; the period is (div+1)*2^WIDTH cycles.
- Compare value: c = REVERSE ? bitrev(cnt) : cnt.
- Output: PWM[i] <= en && (c < active[i]), registered. PWM reflects the current cnt one cycle later.
  - active=0 gives constant 0.
  - active=2^WIDTH-1 is high for all but one count per period.
- Boundary: a step with cnt==2^WIDTH-1 (cnt about to wrap to 0) is the boundary.
  - In that cycle, every channel with PENDING[i]=1 copies shadow[i] into active[i] and clears PENDING[i].
  - TICK is 1 in the following cycle only.
- Writes, WE=1:
  - WADDR<NCH: shadow[WADDR]<=WDATA and PENDING[WADDR]<=1.
  - WADDR==NCH: div<=WDATA[PRE_W-1:0]. The new divider takes effect from the next comparison; pre is not reset.
    - If pre>div after the change, pre keeps counting up, wraps through 2^PRE_W, and then matches.
  - WADDR==NCH+1: en<=WDATA[0]. If WDATA[1]=1 (force load), then in the same cycle:
    - active<=shadow for all channels;
    - PENDING<=0;
    - cnt<=0 and pre<=0, overriding any step that cycle;
    - no TICK is generated.
  - WADDR>NCH+1: ignored, no state change.
- Simultaneous write and boundary on the same channel:
  - The commit uses the shadow value from before the write.
  - The write lands in shadow and PENDING stays 1, so the new value commits at the next boundary.
- en=0: PWM is forced to 0, but the counter, prescaler and commits keep running so phase is preserved.
- RST asserted mid-period or mid-write: all state returns to reset values on that edge, and the write is discarded.
- Widths: all arithmetic is modulo its register width; there is no saturation.

Test Plan:
1. Reset, then REVERSE=0, WIDTH=6, div=0. Write ch0=16, then control=0b11.
   -> PWM[0] high for exactly 16 of each 64 cycles; first high one cycle after the force load. TICK every 64 cycles.
2. REVERSE=1, ch0=32.
   -> PWM[0] toggles every cycle (bitrev MSB = cnt[0]), 32 high per 64. ch0=1 -> high only where cnt==0.
3. Running with ch1 committed at 10, write ch1=50 mid-period.
   -> PENDING[1]=1. PWM[1] keeps 10-count duty until the boundary, then 50-count duty. PENDING[1]=0 after the boundary. TICK asserted the cycle after.
4. Write ch0=20 exactly on the boundary cycle (old shadow 8).
   -> active=8 this period, PENDING stays 1, active=20 after the next boundary.
5. div=3.
   -> cnt advances every 4 cycles, TICK period is 256 cycles. div=0 written while pre=2 -> pre wraps through 15 before resuming.
6. Assert RST for one cycle mid-period with en=1 and PENDING set.
   -> PWM, PENDING and TICK are 0 next cycle, and outputs stay 0 until re-enabled.
   - Write to WADDR=NCH+2 -> no observable change.
